freq_ch_scheduler: RTL and testbench
====================================

# freq_ch_scheduler

Time-multiplexes the two sign-extended ADC channel streams from the channel splitter onto one shared frequency-counter datapath. It sequences settle-discard windows and fixed-length measurement gates per channel. Each gate is framed with `tlast` and tagged with its channel id in `tuser`. It sits between the channel splitter and the single downstream counter in the Frequency_counter design.

## Interface
- `AXIS_TDATA_WIDTH`, 32, sample width on all streams
- `CNT_WIDTH`, 32, width of gate-length and gate counters

- `aclk`  in  1  system clock (125 MHz)
- `aresetn`  in  1  asynchronous, active-low reset; one clock domain only
- `S_AXIS_PORT1_tdata`  in  AXIS_TDATA_WIDTH  channel 0 sample
- `S_AXIS_PORT1_tvalid`  in  1  channel 0 sample valid
- `S_AXIS_PORT2_tdata`  in  AXIS_TDATA_WIDTH  channel 1 sample
- `S_AXIS_PORT2_tvalid`  in  1  channel 1 sample valid
- `cfg_gate_len`  in  CNT_WIDTH  valid samples per gate; 0 treated as 1
- `cfg_settle_len`  in  8  valid samples discarded after a channel switch
- `cfg_ch_en`  in  2  channel enable mask; bit0 = ch0, bit1 = ch1
- `cfg_continuous`  in  1  1 = loop over enabled channels indefinitely
- `start`  in  1  single-cycle run request
- `abort`  in  1  single-cycle stop request
- `M_AXIS_tdata`  out  AXIS_TDATA_WIDTH  forwarded sample
- `M_AXIS_tvalid`  out  1  forwarded sample valid
- `M_AXIS_tlast`  out  1  last sample of a gate
- `M_AXIS_tuser`  out  1  channel id of the forwarded sample
- `busy`  out  1  sequence in progress
- `gates_done`  out  CNT_WIDTH  gates completed since the last start

## Operation
- States: IDLE, SETTLE, GATE.
- **Config latching**
  - All `cfg_*` are latched on an accepted `start`.
  - Changes during a run have no effect.
- **IDLE**
  - `start=1` with `cfg_ch_en!=0` and `abort=0` is accepted.
  - Select the lowest enabled channel and clear `gates_done`.
  - Go to SETTLE, or directly to GATE if `cfg_settle_len==0`.
  - `start` with `cfg_ch_en==0` is ignored.
- **SETTLE**
  - Count valid samples of the selected channel only; the other channel's `tvalid` is ignored.
  - Discarded samples produce no output.
  - When the count reaches `cfg_settle_len`, go to GATE; the next valid sample is the first gate sample.
- **GATE**
  - Forward each valid sample of the selected channel, with `tuser` set to the channel id.
  - On the gate_len-th sample, assert `tlast` and increment `gates_done`. `gates_done` wraps modulo 2^CNT_WIDTH.
  - Then advance to the next enabled channel, in order 0→1→0.
- **Next-channel decision**
  - If advancing wraps past the last enabled channel and `cfg_continuous=0`: go to IDLE.
  - If the next channel differs from the current one: go to SETTLE (or GATE if settle is 0).
  - If the next channel equals the current one (single channel, continuous): go to GATE directly with no settle.
- **Abort**
  - `abort=1` forces IDLE in any state.
  - A sample arriving in the abort cycle is not forwarded.
  - A partial gate is dropped without `tlast`; `gates_done` is not incremented.
  - `abort` and `start` together in IDLE: abort wins and start is ignored.
- `start` while `busy=1` is ignored.
- Counters are CNT_WIDTH-bit unsigned and compare with equality. `cfg_gate_len` up to 2^CNT_WIDTH−1 must work.

## Timing
- **Reset:** `M_AXIS_tdata`=0, `M_AXIS_tvalid`=0, `M_AXIS_tlast`=0, `M_AXIS_tuser`=0, `busy`=0, `gates_done`=0, state IDLE.
- **Output latency:** input sample valid at cycle k → output at cycle k+1.
  - All outputs are registered.
  - `tvalid` pulses one cycle per sample.
  - `tdata`/`tuser` hold their last value when `tvalid`=0.
- **Start:** `start` accepted at cycle N → `busy`=1 from N+1. Samples valid at cycle N are not counted.
- **End of run:** `busy` falls in the cycle after the final `tlast` output, or the cycle after `abort`.
- **Counter update:** `gates_done` updates in the same cycle as the `tlast` output.
- **Back-to-back samples:** no gap is required. A channel switch costs zero idle cycles; the next enabled channel's sample in the cycle after the last gate sample is eligible.
- **Flow control:** there is no backpressure. The downstream consumer must accept every `tvalid` cycle.

## Test plan
- **Single-shot, both channels:** `cfg_ch_en`=3, gate_len=4, settle=2, continuous=0, both tvalid=1 every cycle → 4 ch0 samples (tuser=0, tlast on 4th), then 2 ch1 samples discarded, then 4 ch1 samples (tuser=1, tlast on 4th). `gates_done`=2, then `busy`=0.
- **Continuous, single channel:** `cfg_ch_en`=2, gate_len=3, settle=5, continuous=1 → 5 samples discarded once, then repeated 3-sample gates with no settle between them. `tuser`=1 throughout; `gates_done` counts 1,2,3…
- **Gappy input:** ch0 tvalid on alternate cycles, gate_len=2, settle=0 → `tlast` coincides with the 2nd valid sample, each output one cycle after its input.
- **Abort mid-gate:** abort after 2 of 4 gate samples → no `tlast`, `gates_done` unchanged, `busy`=0 next cycle. Abort together with a sample → that sample is not forwarded.
- **Illegal and corner requests:**
  - `start` with `cfg_ch_en`=0 → `busy` stays 0.
  - gate_len=0 → every sample carries `tlast`.
  - `start`+`abort` together in IDLE → no run.
- **Reset mid-run:** assert `aresetn` low during GATE → all outputs take reset values asynchronously. After release, a new `start` runs correctly.

Source files
------------

// File: rtl/freq_ch_scheduler.sv
// freq_ch_scheduler: time-multiplexes two ADC channel streams onto one counter path with settle and gate windows
module freq_ch_scheduler #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_PORT1_tdata,
  input  logic                        S_AXIS_PORT1_tvalid,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_PORT2_tdata,
  input  logic                        S_AXIS_PORT2_tvalid,
  input  logic [CNT_WIDTH-1:0]        cfg_gate_len,
  input  logic [7:0]                  cfg_settle_len,
  input  logic [1:0]                  cfg_ch_en,
  input  logic                        cfg_continuous,
  input  logic                        start,
  input  logic                        abort,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
  output logic                        M_AXIS_tvalid,
  output logic                        M_AXIS_tlast,
  output logic                        M_AXIS_tuser,
  output logic                        busy,
  output logic [CNT_WIDTH-1:0]        gates_done
);
  typedef enum logic [1:0] {IDLE, SETTLE, GATE} state_t;
  state_t state, state_n;
  logic ch, ch_n, ch_nxt, wrap, sel_valid, fwd, glast, done_run, busy_n, accept, cont;
  logic [1:0] ch_en;
  logic [7:0] settle_len;
  logic [CNT_WIDTH-1:0] cnt, cnt_n, cnt_inc, glen;
  logic [AXIS_TDATA_WIDTH-1:0] sel_data;
  assign sel_valid = ch ? S_AXIS_PORT2_tvalid : S_AXIS_PORT1_tvalid;
  assign sel_data = ch ? S_AXIS_PORT2_tdata : S_AXIS_PORT1_tdata;
  assign cnt_inc = cnt + 1'b1;
  // ch1 always wraps back; ch0 wraps only when ch1 is disabled
  assign wrap = ch | ~ch_en[1];
  assign ch_nxt = (~ch & ch_en[1]) | ~ch_en[0];
  assign accept = state == IDLE && !busy && start && |cfg_ch_en && !abort;
  always_comb begin
    state_n = state;
    ch_n = ch;
    cnt_n = cnt;
    fwd = 1'b0;
    glast = 1'b0;
    done_run = 1'b0;
    if (abort) state_n = IDLE;
    else case (state)
      SETTLE: if (sel_valid) begin
        cnt_n = cnt_inc == CNT_WIDTH'(settle_len) ? '0 : cnt_inc;
        state_n = cnt_inc == CNT_WIDTH'(settle_len) ? GATE : SETTLE;
      end
      GATE: if (sel_valid) begin
        fwd = 1'b1;
        glast = cnt_inc == glen;
        cnt_n = glast ? '0 : cnt_inc;
        if (glast) begin
          done_run = wrap && !cont;
          ch_n = done_run ? ch : ch_nxt;
          state_n = done_run ? IDLE : (ch_nxt != ch && settle_len != 0) ? SETTLE : GATE;
        end
      end
      default: if (accept) begin
        ch_n = ~cfg_ch_en[0];
        cnt_n = '0;
        state_n = cfg_settle_len == 0 ? GATE : SETTLE;
      end
    endcase
    busy_n = !abort && (state_n != IDLE || done_run);
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
      ch <= 1'b0;
      cnt <= '0;
      glen <= CNT_WIDTH'(1);
      settle_len <= '0;
      ch_en <= '0;
      cont <= 1'b0;
      busy <= 1'b0;
      gates_done <= '0;
      M_AXIS_tdata <= '0;
      M_AXIS_tvalid <= 1'b0;
      M_AXIS_tlast <= 1'b0;
      M_AXIS_tuser <= 1'b0;
    end else begin
      state <= state_n;
      ch <= ch_n;
      cnt <= cnt_n;
      busy <= busy_n;
      M_AXIS_tvalid <= fwd;
      M_AXIS_tlast <= glast;
      if (fwd) begin
        M_AXIS_tdata <= sel_data;
        M_AXIS_tuser <= ch;
      end
      if (accept) begin
        glen <= |cfg_gate_len ? cfg_gate_len : CNT_WIDTH'(1);
        settle_len <= cfg_settle_len;
        ch_en <= cfg_ch_en;
        cont <= cfg_continuous;
        gates_done <= '0;
      end else if (glast) gates_done <= gates_done + 1'b1;
    end
  end
endmodule

// File: tb/tb_freq_ch_scheduler.sv
// tb_freq_ch_scheduler: directed vectors for freq_ch_scheduler
module tb_freq_ch_scheduler;
  logic aclk = 1'b0, aresetn = 1'b0;
  logic [31:0] S_AXIS_PORT1_tdata = '0, S_AXIS_PORT2_tdata = '0;
  logic S_AXIS_PORT1_tvalid = 1'b0, S_AXIS_PORT2_tvalid = 1'b0;
  logic [31:0] cfg_gate_len = '0;
  logic [7:0] cfg_settle_len = '0;
  logic [1:0] cfg_ch_en = '0;
  logic cfg_continuous = 1'b0, start = 1'b0, abort = 1'b0;
  logic [31:0] M_AXIS_tdata, gates_done;
  logic M_AXIS_tvalid, M_AXIS_tlast, M_AXIS_tuser, busy;
  int passed = 0, total = 0, n = 0;
  logic [31:0] d1, d2, held;
  freq_ch_scheduler dut (
    .aclk(aclk), .aresetn(aresetn),
    .S_AXIS_PORT1_tdata(S_AXIS_PORT1_tdata), .S_AXIS_PORT1_tvalid(S_AXIS_PORT1_tvalid),
    .S_AXIS_PORT2_tdata(S_AXIS_PORT2_tdata), .S_AXIS_PORT2_tvalid(S_AXIS_PORT2_tvalid),
    .cfg_gate_len(cfg_gate_len), .cfg_settle_len(cfg_settle_len), .cfg_ch_en(cfg_ch_en),
    .cfg_continuous(cfg_continuous), .start(start), .abort(abort),
    .M_AXIS_tdata(M_AXIS_tdata), .M_AXIS_tvalid(M_AXIS_tvalid), .M_AXIS_tlast(M_AXIS_tlast),
    .M_AXIS_tuser(M_AXIS_tuser), .busy(busy), .gates_done(gates_done)
  );
  always #5 aclk = ~aclk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask
  task automatic cfg(input logic [1:0] en, input logic [31:0] gl, input logic [7:0] st, input logic c);
    cfg_ch_en = en;
    cfg_gate_len = gl;
    cfg_settle_len = st;
    cfg_continuous = c;
  endtask
  task automatic cyc(input logic v1, input logic v2, input logic st, input logic ab);
    d1 = 32'h1000_0000 + 32'(n);
    d2 = 32'h2000_0000 + 32'(n);
    n++;
    S_AXIS_PORT1_tdata = d1;
    S_AXIS_PORT2_tdata = d2;
    S_AXIS_PORT1_tvalid = v1;
    S_AXIS_PORT2_tvalid = v2;
    start = st;
    abort = ab;
    @(posedge aclk);
    #1;
    start = 1'b0;
    abort = 1'b0;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    #12;
    check("rst_tvalid", 32'(M_AXIS_tvalid), 0);
    check("rst_tdata", M_AXIS_tdata, 0);
    check("rst_tlast", 32'(M_AXIS_tlast), 0);
    check("rst_tuser", 32'(M_AXIS_tuser), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_gd", gates_done, 0);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    // two channels, single shot, settle before each gate
    cfg(3, 4, 2, 0);
    cyc(1, 1, 1, 0);
    check("t1_busy", 32'(busy), 1);
    check("t1_start_tv", 32'(M_AXIS_tvalid), 0);
    cfg_gate_len = 9;
    for (int i = 0; i < 2; i++) begin
      cyc(1, 1, 0, 0);
      check("t1_set0_tv", 32'(M_AXIS_tvalid), 0);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, 0, 0);
      check("t1_c0_tv", 32'(M_AXIS_tvalid), 1);
      check("t1_c0_tu", 32'(M_AXIS_tuser), 0);
      check("t1_c0_td", M_AXIS_tdata, d1);
      check("t1_c0_tl", 32'(M_AXIS_tlast), 32'(i == 3));
      check("t1_c0_gd", gates_done, 32'(i == 3));
    end
    held = d1;
    for (int i = 0; i < 2; i++) begin
      cyc(1, 1, 0, 0);
      check("t1_set1_tv", 32'(M_AXIS_tvalid), 0);
    end
    check("t1_hold_td", M_AXIS_tdata, held);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, 0, 0);
      check("t1_c1_tv", 32'(M_AXIS_tvalid), 1);
      check("t1_c1_tu", 32'(M_AXIS_tuser), 1);
      check("t1_c1_td", M_AXIS_tdata, d2);
      check("t1_c1_tl", 32'(M_AXIS_tlast), 32'(i == 3));
      check("t1_c1_busy", 32'(busy), 1);
    end
    check("t1_gd", gates_done, 2);
    cyc(1, 1, 0, 0);
    check("t1_end_busy", 32'(busy), 0);
    check("t1_end_tv", 32'(M_AXIS_tvalid), 0);
    // continuous on channel 1 only: settle once, then back-to-back gates
    cfg(2, 3, 5, 1);
    cyc(1, 1, 1, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, 0, 0);
      check("t2_set_tv", 32'(M_AXIS_tvalid), 0);
    end
    for (int g = 0; g < 3; g++)
      for (int i = 0; i < 3; i++) begin
        cyc(1, 1, 0, 0);
        check("t2_tv", 32'(M_AXIS_tvalid), 1);
        check("t2_tu", 32'(M_AXIS_tuser), 1);
        check("t2_td", M_AXIS_tdata, d2);
        check("t2_tl", 32'(M_AXIS_tlast), 32'(i == 2));
        check("t2_gd", gates_done, 32'(g + (i == 2 ? 1 : 0)));
      end
    cyc(1, 1, 0, 1);
    check("t2_abort_tv", 32'(M_AXIS_tvalid), 0);
    check("t2_abort_busy", 32'(busy), 0);
    check("t2_abort_gd", gates_done, 3);
    // gappy ch0, ch1 activity must be ignored
    cfg(1, 2, 0, 0);
    cyc(0, 1, 1, 0);
    check("t3_busy", 32'(busy), 1);
    cyc(1, 1, 0, 0);
    check("t3_s0_tv", 32'(M_AXIS_tvalid), 1);
    check("t3_s0_tl", 32'(M_AXIS_tlast), 0);
    check("t3_s0_td", M_AXIS_tdata, d1);
    cyc(0, 1, 0, 0);
    check("t3_gap_tv", 32'(M_AXIS_tvalid), 0);
    cyc(1, 1, 0, 0);
    check("t3_s1_tv", 32'(M_AXIS_tvalid), 1);
    check("t3_s1_tl", 32'(M_AXIS_tlast), 1);
    check("t3_s1_tu", 32'(M_AXIS_tuser), 0);
    check("t3_gd", gates_done, 1);
    cyc(0, 0, 0, 0);
    check("t3_end_busy", 32'(busy), 0);
    // abort mid-gate with a coincident sample
    cfg(1, 4, 0, 0);
    cyc(1, 1, 1, 0);
    check("t4_gd_clr", gates_done, 0);
    for (int i = 0; i < 2; i++) begin
      cyc(1, 0, 0, 0);
      check("t4_tv", 32'(M_AXIS_tvalid), 1);
      check("t4_tl", 32'(M_AXIS_tlast), 0);
    end
    cyc(1, 0, 0, 1);
    check("t4_abort_tv", 32'(M_AXIS_tvalid), 0);
    check("t4_abort_tl", 32'(M_AXIS_tlast), 0);
    check("t4_abort_busy", 32'(busy), 0);
    check("t4_abort_gd", gates_done, 0);
    // corner requests
    cfg(0, 4, 0, 0);
    cyc(1, 1, 1, 0);
    check("t5_noen_busy", 32'(busy), 0);
    cfg(1, 0, 0, 1);
    cyc(1, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0);
      check("t5_gl0_tl", 32'(M_AXIS_tlast), 1);
      check("t5_gl0_gd", gates_done, 32'(i + 1));
    end
    cyc(1, 0, 0, 1);
    cfg(3, 4, 0, 0);
    cyc(1, 1, 1, 1);
    check("t5_sa_busy", 32'(busy), 0);
    cyc(1, 1, 0, 0);
    check("t5_sa_tv", 32'(M_AXIS_tvalid), 0);
    check("t5_sa_busy2", 32'(busy), 0);
    // asynchronous reset mid-gate, then a fresh run
    cyc(1, 1, 1, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    check("t6_pre_tv", 32'(M_AXIS_tvalid), 1);
    #2 aresetn = 1'b0;
    #1;
    check("t6_rst_tv", 32'(M_AXIS_tvalid), 0);
    check("t6_rst_td", M_AXIS_tdata, 0);
    check("t6_rst_tu", 32'(M_AXIS_tuser), 0);
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_gd", gates_done, 0);
    #2 aresetn = 1'b1;
    @(posedge aclk);
    #1;
    cfg(1, 1, 0, 0);
    cyc(1, 1, 1, 0);
    cyc(1, 0, 0, 0);
    check("t6_tv", 32'(M_AXIS_tvalid), 1);
    check("t6_tl", 32'(M_AXIS_tlast), 1);
    check("t6_td", M_AXIS_tdata, d1);
    check("t6_gd", gates_done, 1);
    cyc(0, 0, 0, 0);
    check("t6_end_busy", 32'(busy), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
